base_cntr_scan: RTL and testbench
=================================

# base_cntr_scan

Read sequencer that sits directly downstream of the SRAM-backed counter array and drives its read port. On a start request it walks every counter address 0..n-1, keeps a bounded number of reads in flight, and tags each returned value with its address. It emits the values as a valid/ready stream (address, data, last) for the MMIO / debug-dump path.

## Interface
- `width`, 32: counter data width; must match the counter array.
- `n`, 4: number of counters; n >= 2.
- `addr_width`, $clog2(n): counter address width.
- `max_out`, 4: maximum outstanding reads; 1..7.

Clock is `clk`. `reset` is synchronous and active-high.

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `i_start_v`  in  1  scan request
- `i_start_r`  out  1  scan request accepted (high only in IDLE)
- `o_busy`  out  1  scan in progress
- `o_rd_v`  out  1  read request valid, to counter array `i_rd_v`
- `o_rd_r`  in  1  read request ready, from counter array `i_rd_r`
- `o_rd_a`  out  addr_width  read address
- `i_rd_v`  in  1  read data valid, from counter array `o_rd_v`
- `i_rd_r`  out  1  read data ready, to counter array `o_rd_r`
- `i_rd_d`  in  width  read data
- `o_v`  out  1  output beat valid
- `o_r`  in  1  output beat ready
- `o_a`  out  addr_width  counter address of beat
- `o_d`  out  width  counter value
- `o_last`  out  1  beat is the final one of the scan

## Operation
- States:
  - IDLE: `i_start_r`=1.
  - ISSUE: `o_rd_v`=1 while `outst` < `max_out`.
  - DRAIN: `o_rd_v`=0.
- State transitions:
  - IDLE -> ISSUE on `i_start_v`. Clear `req_a`, `rsp_a` and `outst`.
  - ISSUE -> DRAIN when a request with `req_a` = n-1 is accepted.
  - DRAIN -> IDLE when the beat with `o_last`=1 is accepted (`o_v` & `o_r`).
- `o_rd_a` = `req_a`. `req_a` increments on each accepted request (`o_rd_v` & `o_rd_r`).
- `outst` is $clog2(max_out+1) bits wide.
  - +1 on request accept; -1 on response accept (`i_rd_v` & `i_rd_r`).
  - Both in the same cycle: unchanged.
  - Never exceeds `max_out` and never underflows.
- Responses return in order. The response address is `rsp_a`, which increments on each response accept.
- Output register (one entry) captures {`rsp_a`, `i_rd_d`, `rsp_a`==n-1}.
  - `i_rd_r` = ~`o_v` | `o_r`: full throughput while not backpressured.
- `o_busy` = state != IDLE.
- In IDLE, `i_rd_r`=1 and any stray response is discarded (no output beat).
- `i_start_v` while busy is ignored; the start is not queued.
- Wrap-around: `req_a` and `rsp_a` stop at n-1. They do not wrap within a scan.
- Reset mid-scan: state -> IDLE; `outst`, `req_a`, `rsp_a` and the output register are cleared. Any in-flight scan is abandoned.

## Timing
- Reset values: `i_start_r`=1, `o_busy`=0, `o_rd_v`=0, `o_rd_a`=0, `i_rd_r`=1, `o_v`=0, `o_a`=0, `o_d`=0, `o_last`=0.
- Start accepted at cycle T: `o_busy`=1 and `o_rd_v`=1 with address 0 at T+1.
- With no backpressure: one request per cycle until n requests have issued or `max_out` is reached.
- Response accepted at cycle T: `o_v`=1 with that data at T+1. Data is held stable until `o_r`.
- `o_v` is not combinationally dependent on `o_r`. `i_rd_r` depends combinationally on `o_r` only.
- Returning to IDLE after the last beat: `i_start_r`=1 in the next cycle.

## Configuration
- `BASE_CNTR_SCAN_SKIPZ_EN` defined: responses with `i_rd_d`==0 and `rsp_a` != n-1 are consumed (counted and acknowledged) but produce no output beat. The last counter always produces a beat, so `o_last` is always delivered.
- Undefined: every counter produces exactly one beat; n beats per scan.

## Structure
- Package `base_cntr_scan_pkg`: state enum {IDLE, ISSUE, DRAIN} and the default `max_out` constant.
- One sub-module: `base_alatch` (width = addr_width+width+1) as the output register providing the valid/ready stage.
- The FSM, `req_a`/`rsp_a`/`outst` counters and the skip filter live in the top.

## Test plan
- n=4, counters {5,0,7,9}, `o_r`=1, skip undefined. Pulse start -> beats (0,5),(1,0),(2,7),(3,9,last). `o_busy` falls the cycle after the last beat.
- Same stimulus with `BASE_CNTR_SCAN_SKIPZ_EN` -> beats (0,5),(2,7),(3,9,last). Counters {0,0,0,0} -> single beat (3,0,last).
- `max_out`=2, `i_rd_v` held low for 10 cycles -> exactly 2 requests issued, then `o_rd_v`=0 until a response arrives. `outst` never exceeds 2.
- `o_r`=0 for 8 cycles mid-scan -> `o_d` stable and `i_rd_r`=0. After release all n beats are delivered, in order, with no loss or duplication.
- `i_start_v` held high for 2 scans, n=4 -> exactly 8 beats. The second scan's first request follows the first scan's last-beat accept.
- `reset` asserted after 2 beats -> next cycle all outputs at reset values. A new start yields a full fresh scan from address 0.

Source files
------------

// File: rtl/base_cntr_scan_pkg.sv
// Shared types and constants for the counter-array read scanner.
// Optional zero-skip filter is enabled by defining BASE_CNTR_SCAN_SKIPZ_EN.
package base_cntr_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int MAX_OUT_DEFAULT = 4;

    // Width of a counter that must hold 0..m inclusive.
    function automatic int outst_width(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/base_cntr_scan_if.sv
// Bundle of the scan request, counter-array read port and output beat stream.
interface base_cntr_scan_if #(
    parameter int width      = 32,
    parameter int addr_width = 2
);
    logic                  i_start_v;
    logic                  i_start_r;
    logic                  o_busy;
    logic                  o_rd_v;
    logic                  o_rd_r;
    logic [addr_width-1:0] o_rd_a;
    logic                  i_rd_v;
    logic                  i_rd_r;
    logic [width-1:0]      i_rd_d;
    logic                  o_v;
    logic                  o_r;
    logic [addr_width-1:0] o_a;
    logic [width-1:0]      o_d;
    logic                  o_last;

    modport master (
        input  i_start_v, o_rd_r, i_rd_v, i_rd_d, o_r,
        output i_start_r, o_busy, o_rd_v, o_rd_a, i_rd_r, o_v, o_a, o_d, o_last
    );

    modport slave (
        output i_start_v, o_rd_r, i_rd_v, i_rd_d, o_r,
        input  i_start_r, o_busy, o_rd_v, o_rd_a, i_rd_r, o_v, o_a, o_d, o_last
    );

endinterface

// File: rtl/base_alatch.sv
// One-entry valid/ready register stage; accepts a new word whenever empty or
// being drained in the same cycle, so o_v never depends on o_r.
module base_alatch #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_v,
    output logic             i_r,
    input  logic [width-1:0] i_d,
    output logic             o_v,
    input  logic             o_r,
    output logic [width-1:0] o_d
);

    logic             v_q, v_d;
    logic [width-1:0] d_q, d_d;

    assign i_r = !v_q || o_r;
    assign o_v = v_q;
    assign o_d = d_q;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (i_v && i_r) begin
            v_d = 1'b1;
            d_d = i_d;
        end else if (o_r) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

endmodule

// File: rtl/base_cntr_scan.sv
// Walks counter addresses 0..n-1 with bounded outstanding reads and streams
// {address, value, last}. Define BASE_CNTR_SCAN_SKIPZ_EN to drop zero counters.
module base_cntr_scan
    import base_cntr_scan_pkg::*;
#(
    parameter int width      = 32,
    parameter int n          = 4,
    parameter int addr_width = $clog2(n),
    parameter int max_out    = MAX_OUT_DEFAULT
) (
    input logic              clk,
    input logic              reset,
    base_cntr_scan_if.master bus
);

    localparam int OW = outst_width(max_out);
    localparam int BW = addr_width + width + 1;

    localparam logic [1:0]            ST_IDLE  = 2'(IDLE);
    localparam logic [1:0]            ST_ISSUE = 2'(ISSUE);
    localparam logic [1:0]            ST_DRAIN = 2'(DRAIN);
    localparam logic [addr_width-1:0] LAST_A   = addr_width'(n - 1);
    localparam logic [OW-1:0]         MAX_O    = OW'(max_out);

    logic [1:0]            state_q, state_d;
    logic [addr_width-1:0] req_a_q, req_a_d;
    logic [addr_width-1:0] rsp_a_q, rsp_a_d;
    logic [OW-1:0]         outst_q, outst_d;

    logic          busy;
    logic          rd_acc;
    logic          rsp_acc;
    logic          rsp_take;
    logic          keep;
    logic          lat_iv;
    logic          lat_ir;
    logic          lat_ov;
    logic [BW-1:0] lat_id;
    logic [BW-1:0] lat_od;
    logic          beat_acc;

    assign busy          = (state_q != ST_IDLE);
    assign bus.i_start_r = (state_q == ST_IDLE);
    assign bus.o_busy    = busy;
    assign bus.o_rd_v    = (state_q == ST_ISSUE) && (outst_q < MAX_O);
    assign bus.o_rd_a    = req_a_q;
    // Responses outside a scan are always acknowledged and then dropped.
    assign bus.i_rd_r    = !busy || lat_ir;

    assign rd_acc   = bus.o_rd_v && bus.o_rd_r;
    assign rsp_acc  = bus.i_rd_v && bus.i_rd_r;
    assign rsp_take = rsp_acc && busy && (outst_q != '0);

`ifdef BASE_CNTR_SCAN_SKIPZ_EN
    assign keep = (bus.i_rd_d != '0) || (rsp_a_q == LAST_A);
`else
    assign keep = 1'b1;
`endif

    assign lat_iv   = rsp_take && keep;
    assign lat_id   = {rsp_a_q, bus.i_rd_d, (rsp_a_q == LAST_A)};
    assign bus.o_v  = lat_ov;
    assign {bus.o_a, bus.o_d, bus.o_last} = lat_od;
    assign beat_acc = lat_ov && bus.o_r;

    base_alatch #(.width(BW)) u_out (
        .clk   (clk),
        .reset (reset),
        .i_v   (lat_iv),
        .i_r   (lat_ir),
        .i_d   (lat_id),
        .o_v   (lat_ov),
        .o_r   (bus.o_r),
        .o_d   (lat_od)
    );

    always_comb begin
        state_d = state_q;
        req_a_d = req_a_q;
        rsp_a_d = rsp_a_q;
        outst_d = outst_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start_v) begin
                    state_d = ST_ISSUE;
                    req_a_d = '0;
                    rsp_a_d = '0;
                    outst_d = '0;
                end
            end
            ST_ISSUE: begin
                if (rd_acc && (req_a_q == LAST_A)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (beat_acc && bus.o_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Addresses saturate at n-1 so a scan never wraps onto counter 0.
        if (busy) begin
            if (rd_acc && (req_a_q != LAST_A))   req_a_d = req_a_q + 1'b1;
            if (rsp_take && (rsp_a_q != LAST_A)) rsp_a_d = rsp_a_q + 1'b1;
            if (rd_acc && !rsp_take)             outst_d = outst_q + 1'b1;
            else if (!rd_acc && rsp_take)        outst_d = outst_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_a_q <= '0;
            rsp_a_q <= '0;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            req_a_q <= req_a_d;
            rsp_a_q <= rsp_a_d;
            outst_q <= outst_d;
        end
    end

endmodule

// File: tb/tb_base_cntr_scan.sv
// Directed bench for base_cntr_scan (n=4, max_out=2) with a one-cycle-latency
// counter-array model; expectations follow BASE_CNTR_SCAN_SKIPZ_EN when defined.
module tb_base_cntr_scan;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int AW = 2;
    localparam int MO = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    base_cntr_scan_if #(.width(W), .addr_width(AW)) bus ();

    base_cntr_scan #(.width(W), .n(N), .max_out(MO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        logic          last;
    } beat_t;

    typedef struct {
        logic [W-1:0]  cnt [N];
        int            nb;
        logic [AW-1:0] ea  [N];
        logic [W-1:0]  ed  [N];
    } vec_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [W-1:0]  mem [N];
    logic          rsp_en;
    logic [AW-1:0] pend [$];
    beat_t         beats [$];
    int            max_pend;
    int            req_cnt;
    int            start_cnt;
    int            cyc = 0;
    int            last_beat_cyc = 0;
    int            start_gap = 0;
    vec_t          vecs [4];

    // Counter-array model and stream monitor, sampled on the active edge.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            pend.delete();
        end else begin
            if (bus.i_rd_v && bus.i_rd_r && pend.size() > 0) void'(pend.pop_front());
            if (bus.o_rd_v && bus.o_rd_r) begin
                pend.push_back(bus.o_rd_a);
                req_cnt++;
                if (bus.o_rd_a == '0) start_gap = cyc - last_beat_cyc;
            end
            if (pend.size() > max_pend) max_pend = pend.size();
            if (bus.o_v && bus.o_r) begin
                beats.push_back('{a: bus.o_a, d: bus.o_d, last: bus.o_last});
                if (bus.o_last) last_beat_cyc = cyc;
            end
            if (bus.i_start_v && bus.i_start_r) start_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rsp_en && pend.size() > 0) begin
            bus.i_rd_v = 1'b1;
            bus.i_rd_d = mem[pend[0]];
        end else begin
            bus.i_rd_v = 1'b0;
            bus.i_rd_d = '0;
        end
    end

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_start_r"}, 32'(bus.i_start_r), 32'd1);
        checkOutput({tag, "_busy"},    32'(bus.o_busy),    32'd0);
        checkOutput({tag, "_rd_v"},    32'(bus.o_rd_v),    32'd0);
        checkOutput({tag, "_rd_a"},    32'(bus.o_rd_a),    32'd0);
        checkOutput({tag, "_i_rd_r"},  32'(bus.i_rd_r),    32'd1);
        checkOutput({tag, "_o_v"},     32'(bus.o_v),       32'd0);
        checkOutput({tag, "_o_a"},     32'(bus.o_a),       32'd0);
        checkOutput({tag, "_o_d"},     bus.o_d,            32'd0);
        checkOutput({tag, "_o_last"},  32'(bus.o_last),    32'd0);
    endtask

    task automatic startScan(input string tag);
        @(negedge clk);
        checkOutput({tag, "_start_ready"}, 32'(bus.i_start_r), 32'd1);
        bus.i_start_v = 1'b1;
        @(negedge clk);
        bus.i_start_v = 1'b0;
    endtask

    // Waits for the final beat to be accepted, then checks the return to idle.
    task automatic waitLastBeat(input string tag);
        int t = 0;
        while (!(bus.o_v && bus.o_r && bus.o_last) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            failNow({tag, "_last_beat"});
        end else begin
            @(negedge clk);
            checkOutput({tag, "_busy_fall"}, 32'(bus.o_busy),    32'd0);
            checkOutput({tag, "_idle_rdy"},  32'(bus.i_start_r), 32'd1);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [W-1:0] cnt [N]);
        mem = cnt;
        beats.delete();
        startScan(tag);
        checkOutput({tag, "_busy_t1"}, 32'(bus.o_busy), 32'd1);
        checkOutput({tag, "_rd_v_t1"}, 32'(bus.o_rd_v), 32'd1);
        checkOutput({tag, "_rd_a_t1"}, 32'(bus.o_rd_a), 32'd0);
        waitLastBeat(tag);
    endtask

    task automatic checkSeqBeats(input string tag, input logic [W-1:0] cnt [N], input int reps);
        checkOutput({tag, "_nbeats"}, 32'(beats.size()), 32'(N * reps));
        for (int i = 0; i < beats.size() && i < N * reps; i++) begin
            checkOutput($sformatf("%s_a%0d", tag, i), 32'(beats[i].a), 32'(i % N));
            checkOutput($sformatf("%s_d%0d", tag, i), beats[i].d, cnt[i % N]);
            checkOutput($sformatf("%s_l%0d", tag, i), 32'(beats[i].last), 32'((i % N) == N - 1));
        end
    endtask

    initial begin
        logic [W-1:0] seq [N];
        logic [W-1:0] held;
        int t;

        reset         = 1'b1;
        bus.i_start_v = 1'b0;
        bus.o_rd_r    = 1'b1;
        bus.o_r       = 1'b1;
        rsp_en        = 1'b1;
        max_pend      = 0;
        req_cnt       = 0;
        start_cnt     = 0;

        vecs[0].cnt = '{32'd5, 32'd0, 32'd7, 32'd9};
        vecs[1].cnt = '{32'd0, 32'd0, 32'd0, 32'd0};
        vecs[2].cnt = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
        vecs[3].cnt = '{32'd0, 32'h1234_5678, 32'd0, 32'h8000_0000};
`ifdef BASE_CNTR_SCAN_SKIPZ_EN
        vecs[0].nb = 3; vecs[0].ea = '{2'd0, 2'd2, 2'd3, 2'd0}; vecs[0].ed = '{32'd5, 32'd7, 32'd9, 32'd0};
        vecs[1].nb = 1; vecs[1].ea = '{2'd3, 2'd0, 2'd0, 2'd0}; vecs[1].ed = '{32'd0, 32'd0, 32'd0, 32'd0};
        vecs[2].nb = 3; vecs[2].ea = '{2'd0, 2'd1, 2'd3, 2'd0}; vecs[2].ed = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
        vecs[3].nb = 2; vecs[3].ea = '{2'd1, 2'd3, 2'd0, 2'd0}; vecs[3].ed = '{32'h1234_5678, 32'h8000_0000, 32'd0, 32'd0};
`else
        vecs[0].nb = 4; vecs[0].ea = '{2'd0, 2'd1, 2'd2, 2'd3}; vecs[0].ed = '{32'd5, 32'd0, 32'd7, 32'd9};
        vecs[1].nb = 4; vecs[1].ea = '{2'd0, 2'd1, 2'd2, 2'd3}; vecs[1].ed = '{32'd0, 32'd0, 32'd0, 32'd0};
        vecs[2].nb = 4; vecs[2].ea = '{2'd0, 2'd1, 2'd2, 2'd3}; vecs[2].ed = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
        vecs[3].nb = 4; vecs[3].ea = '{2'd0, 2'd1, 2'd2, 2'd3}; vecs[3].ed = '{32'd0, 32'h1234_5678, 32'd0, 32'h8000_0000};
`endif

        repeat (3) @(negedge clk);
        checkResetValues("por");
        reset = 1'b0;

        $display("[TB] table-driven scans");
        for (int v = 0; v < 4; v++) begin
            applyStimulus($sformatf("vec%0d", v), vecs[v].cnt);
            checkOutput($sformatf("vec%0d_nbeats", v), 32'(beats.size()), 32'(vecs[v].nb));
            for (int i = 0; i < vecs[v].nb && i < beats.size(); i++) begin
                checkOutput($sformatf("vec%0d_a%0d", v, i), 32'(beats[i].a), 32'(vecs[v].ea[i]));
                checkOutput($sformatf("vec%0d_d%0d", v, i), beats[i].d, vecs[v].ed[i]);
                checkOutput($sformatf("vec%0d_l%0d", v, i), 32'(beats[i].last), 32'(i == vecs[v].nb - 1));
            end
        end

        $display("[TB] outstanding limit with responses stalled");
        seq = '{32'd1, 32'd2, 32'd3, 32'd4};
        mem = seq;
        beats.delete();
        rsp_en = 1'b0;
        req_cnt = 0;
        max_pend = 0;
        startScan("mo");
        repeat (10) @(negedge clk);
        checkOutput("mo_req_cnt",  32'(req_cnt),    32'd2);
        checkOutput("mo_rd_v_low", 32'(bus.o_rd_v), 32'd0);
        checkOutput("mo_busy",     32'(bus.o_busy), 32'd1);
        rsp_en = 1'b1;
        waitLastBeat("mo");
        checkOutput("mo_max_pend", 32'(max_pend), 32'd2);
        checkSeqBeats("mo", seq, 1);

        $display("[TB] output backpressure");
        seq = '{32'd11, 32'd22, 32'd33, 32'd44};
        mem = seq;
        beats.delete();
        startScan("bp");
        t = 0;
        while (!bus.o_v && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) failNow("bp_first_beat");
        bus.o_r = 1'b0;
        held = bus.o_d;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_hold_d%0d", i), bus.o_d, held);
            checkOutput($sformatf("bp_rd_r%0d", i), 32'(bus.i_rd_r), 32'd0);
        end
        bus.o_r = 1'b1;
        waitLastBeat("bp");
        checkSeqBeats("bp", seq, 1);

        $display("[TB] start held for two scans");
        seq = '{32'd1, 32'd2, 32'd3, 32'd4};
        mem = seq;
        beats.delete();
        start_cnt = 0;
        @(negedge clk);
        bus.i_start_v = 1'b1;
        t = 0;
        while (start_cnt < 2 && t < 300) begin
            @(negedge clk);
            t++;
        end
        bus.i_start_v = 1'b0;
        if (t >= 300) failNow("hold_second_start");
        waitLastBeat("hold");
        checkOutput("hold_starts", 32'(start_cnt), 32'd2);
        checkOutput("hold_gap",    32'(start_gap), 32'd2);
        checkSeqBeats("hold", seq, 2);

        $display("[TB] reset mid-scan");
        mem = seq;
        beats.delete();
        startScan("rst");
        t = 0;
        while (beats.size() < 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) failNow("rst_two_beats");
        reset = 1'b1;
        @(negedge clk);
        checkResetValues("rst");
        reset = 1'b0;
        seq = '{32'd6, 32'd7, 32'd8, 32'd10};
        applyStimulus("fresh", seq);
        checkSeqBeats("fresh", seq, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
